// File: rtl/fir_stream_pkg.sv
// fir_stream_pkg: sizing and constant helpers shared by the FIR datapath.
package fir_stream_pkg;

    function automatic int acc_width(int dw, int cw, int nt);
        return dw + cw + $clog2(nt);
    endfunction

    function automatic int reset_coef(int cw, int k);
        return (k == 0) ? (1 << (cw - 1)) - 1 : 0;
    endfunction

    function automatic int round_offset(int cw);
        return 1 << (cw - 2);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: round half-up, arithmetic shift and saturate an accumulator to the output width.
module fir_round_sat
    import fir_stream_pkg::*;
#(
    parameter int IN_W  = 19,
    parameter int OUT_W = 8,
    parameter int SHIFT = 7
) (
    input  logic signed [IN_W-1:0]  acc_i,
    output logic signed [OUT_W-1:0] y_o
);
    localparam logic signed [IN_W-1:0] OFS  = IN_W'(round_offset(SHIFT + 1));
    localparam logic signed [IN_W-1:0] MAXV = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] MINV = -MAXV - IN_W'(1);

    logic signed [IN_W-1:0] shifted;

    assign shifted = (acc_i + OFS) >>> SHIFT;

    always_comb
        y_o = (shifted > MAXV) ? OUT_W'(MAXV) :
              (shifted < MINV) ? OUT_W'(MINV) : shifted[OUT_W-1:0];

endmodule

// File: rtl/fir_stream.sv
// fir_stream: programmable direct-form FIR with valid/ready handshake, rounding and saturation.
module fir_stream
    import fir_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int NUM_TAPS   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]  coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wr_data
);
    localparam int AW = acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);

    logic signed [COEF_WIDTH-1:0] c_q [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0] c_d [NUM_TAPS];
    // Tap 0 is the incoming sample, so only NUM_TAPS-1 history entries are stored.
    logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS-1];
    logic signed [DATA_WIDTH-1:0] x_d [NUM_TAPS-1];
    logic signed [DATA_WIDTH-1:0] out_q, out_d, y;
    logic                         out_valid_q, out_valid_d, accept;
    logic signed [AW-1:0]         acc;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;

    always_comb begin
        acc = AW'(in) * AW'(c_q[0]);
        for (int k = 1; k < NUM_TAPS; k++)
            acc += AW'(x_q[k-1]) * AW'(c_q[k]);
    end

    fir_round_sat #(
        .IN_W  (AW),
        .OUT_W (DATA_WIDTH),
        .SHIFT (COEF_WIDTH - 1)
    ) u_round_sat (
        .acc_i (acc),
        .y_o   (y)
    );

    always_comb begin
        c_d         = c_q;
        x_d         = x_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        if (clear) begin
            x_d         = '{default: '0};
            out_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            x_d[0] = in;
            for (int k = 1; k < NUM_TAPS - 1; k++)
                x_d[k] = x_q[k-1];
            out_d       = y;
            out_valid_d = 1'b1;
        end
        if (coef_wr_en && int'(coef_wr_addr) < NUM_TAPS)
            c_d[coef_wr_addr] = coef_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++)
                c_q[k] <= COEF_WIDTH'(reset_coef(COEF_WIDTH, k));
            x_q         <= '{default: '0};
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            x_q         <= x_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fir_stream.sv
// tb_fir_stream: randomized and directed scoreboard bench for a 3-tap 8-bit fir_stream.
module tb_fir_stream;
    localparam int NT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic signed [7:0] in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] out;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              coef_wr_en = 1'b0;
    logic [1:0]        coef_wr_addr = '0;
    logic signed [7:0] coef_wr_data = '0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int hist[$];
    int cm[NT] = '{127, 0, 0};

    fir_stream #(.DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_TAPS(NT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in           (in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out          (out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data)
    );

    always #10 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: exact dot product, then round half-up by floor division and clamp.
    function automatic int model_y();
        int s = 0;
        int r;
        for (int k = 0; k < hist.size(); k++) s += cm[k] * hist[k];
        s += 64;
        r = (s >= 0) ? s / 128 : -((-s + 127) / 128);
        return (r > 127) ? 127 : (r < -128) ? -128 : r;
    endfunction

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (clear) begin
                hist.delete();
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                hist.push_front(int'(in));
                if (hist.size() > NT) void'(hist.pop_back());
                exp_q.push_back(model_y());
            end
            if (coef_wr_en && coef_wr_addr < NT) cm[coef_wr_addr] = int'(coef_wr_data);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("in_ready", int'(in_ready), int'(exp_q.size() == 0 || out_ready));
            if (out_valid && exp_q.size() != 0) begin
                chk("out", int'(out), exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int v, input logic vld, input logic ordy, input logic clr);
        @(posedge clk);
        #1;
        in         = 8'(v);
        in_valid   = vld;
        out_ready  = ordy;
        clear      = clr;
        coef_wr_en = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        step(0, 1'b0, 1'b1, 1'b0);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 2'(a);
        coef_wr_data = 8'(d);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(0, 1'b0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0);
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #15 rst_n = 1'b1;
        chk("rst_out", int'(out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        step(100, 1'b1, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1, 1'b0);
        chk("passthrough_99", int'(out), 99);
        drain();

        wr(0, -38); wr(1, 64); wr(2, 37);
        step(0, 1'b0, 1'b1, 1'b1);
        step(127, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 10; i++) step(127, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0);
        chk("dc_gain_63", int'(out), 63);
        drain();

        wr(0, 127); wr(1, 127); wr(2, 0);
        for (int i = 0; i < 4; i++) step(127, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0);
        chk("sat_pos", int'(out), 127);
        for (int i = 0; i < 4; i++) step(-128, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0);
        chk("sat_neg", int'(out), -128);
        drain();

        wr(0, -38); wr(1, 64); wr(2, 37);
        step(0, 1'b0, 1'b1, 1'b1);
        step(127, 1'b1, 1'b0, 1'b0);
        step(5, 1'b1, 1'b0, 1'b0);
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_out", int'(out), -38);
        chk("stall_in_ready", int'(in_ready), 0);
        step(9, 1'b1, 1'b0, 1'b0);
        chk("stall_hold", int'(out), -38);
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, 1'b0);
        drain();

        step(50, 1'b1, 1'b1, 1'b0);
        step(60, 1'b1, 1'b1, 1'b1);
        step(0, 1'b0, 1'b1, 1'b0);
        chk("clear_out", int'(out), 0);
        chk("clear_valid", int'(out_valid), 0);
        step(127, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0);
        chk("clear_keeps_coef", int'(out), -38);
        drain();

        step(50, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", int'(out), 0);
        chk("arst_valid", int'(out_valid), 0);
        exp_q.delete();
        hist.delete();
        cm = '{127, 0, 0};
        #1 rst_n = 1'b1;
        step(100, 1'b1, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0);
        chk("arst_coef_default", int'(out), 99);
        drain();

        for (int i = 0; i < NT; i++) wr(i, $urandom_range(255));
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(255), ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 60) == 0);
            coef_wr_en   = ($urandom % 20) == 0;
            coef_wr_addr = 2'($urandom_range(3));
            coef_wr_data = 8'($urandom_range(255));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_stream.md
# fir_stream

Parametrised, runtime-programmable direct-form FIR filter with full valid/ready backpressure, rounding and output saturation. Generalises the fixed 3-tap 8-bit filter to arbitrary data width, coefficient width and tap count. It sits in the sample datapath between a streaming source (ADC/decimator) and a downstream consumer that may stall. Coefficients are loaded through a simple write port.

## Interface
- DATA_WIDTH, 8: signed sample width, input and output.
- COEF_WIDTH, 8: signed coefficient width, Q1.(COEF_WIDTH-1) format.
- NUM_TAPS, 8: number of taps, ≥2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of the delay line and output register; coefficients kept.
- in  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- out  out  DATA_WIDTH  signed filtered sample.
- out_valid  out  1  out holds an unconsumed sample.
- out_ready  in  1  consumer accepts out this cycle.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  $clog2(NUM_TAPS)  tap index; 0 multiplies the newest sample.
- coef_wr_data  in  COEF_WIDTH  signed coefficient value.

## Operation
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready, combinational, with no dependency on in_valid.
- On accept: the delay line shifts, x[0] <= in. The output register loads y = Σ c[k]·x[k], computed from the new sample and the pre-shift delay line. out_valid <= 1.
- On out_ready && out_valid without accept: out_valid <= 0. out holds its last value.
- Without accept, the delay line and out are frozen and in is ignored.
- Arithmetic:
  - Products are full precision. Accumulator width is DATA_WIDTH+COEF_WIDTH+$clog2(NUM_TAPS).
  - Round half-up: add 2^(COEF_WIDTH-2), then arithmetic shift right by COEF_WIDTH-1.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Coefficient write: c[coef_wr_addr] <= coef_wr_data.
  - Addresses ≥ NUM_TAPS are ignored.
  - If a write and an accept occur in the same cycle, the accept uses the old coefficient.
- clear: delay line <= 0, out <= 0, out_valid <= 0. clear has priority over a same-cycle accept; that sample is dropped.

## Timing
- Reset (rst_n low, asynchronous):
  - out = 0, out_valid = 0, in_ready = 1.
  - Delay line = 0.
  - c[0] = 2^(COEF_WIDTH-1)-1, all other c[k] = 0 (near-passthrough).
- Latency: a sample accepted at edge n appears on out after edge n, one cycle.
- Throughput: one sample per cycle while out_ready is held high.
- Full stall: out_valid=1 and out_ready=0 gives in_ready=0. out stays stable until consumed.
- Reset asserted mid-operation discards all state immediately, with no partial output. Release is synchronised externally.

## Structure
- Package fir_stream_pkg holds:
  - acc_width() function.
  - Reset coefficient constant function.
  - Rounding offset constant.
- Sub-module fir_round_sat: combinational round + saturate, parametrised on input and output widths.
- Coefficients and delay line are register arrays; no RAM inference.

## Test plan
- Reset, out_ready=1, input 100 once then 0 → out 99 for one valid cycle, then 0.
- Write c = {-38, 64, 37}, NUM_TAPS=3, impulse 127 → out sequence -38, 64, 37, 0.
- Same coefficients, constant input 127 for 10 samples → steady out 63 (DC gain).
- Saturation:
  - c = {127, 127, 0}, constant 127 → out saturates at 127.
  - Constant -128 → out saturates at -128.
- Backpressure:
  - Impulse with out_ready=0 → out_valid=1, out=-38 held, in_ready=0, in ignored.
  - Release out_ready → the remaining response completes in order with no lost or duplicated samples.
- Mid-stream checks:
  - Assert clear → out=0 and out_valid=0 next cycle; coefficients retained.
  - Pulse rst_n low between edges → out=0 and out_valid=0 immediately; coefficients return to default.
